nts_dispatcher_port: RTL and testbench

- Producer end of the dispatch interface that the NTS engine consumes.
- Accepts 64-bit frames from the MAC receive path and stores one complete frame in a single-packet RAM.
- Once a good frame has fully landed, exposes it as a read-on-demand FIFO: packet-available flag, empty flag, last-word byte mask, 64-bit read data.
- Frees the buffer when the engine pulses read/discard.

---
 rtl/nts_dispatcher_port.sv | 214 +++++++++++++++++++++
 tb/tb_nts_dispatcher_port.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_dispatcher_port.sv
// Single-packet buffer between the MAC receive path and the NTS engine: stores one good frame and serves it as a FIFO.
// Build option: define NTS_DISPATCHER_COUNTERS_EN for live packet/drop counters; otherwise they read as zero.
module nts_dispatcher_port #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic [7:0]  i_rx_data_valid,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_good_frame,
    input  logic        i_rx_bad_frame,
    output logic        o_dispatch_packet_available,
    input  logic        i_dispatch_packet_read_discard,
    output logic [7:0]  o_dispatch_data_valid,
    output logic        o_dispatch_fifo_empty,
    input  logic        i_dispatch_fifo_rd_en,
    output logic [63:0] o_dispatch_fifo_rd_data,
    output logic [31:0] o_counter_packets,
    output logic [31:0] o_counter_drops
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECEIVE, ST_DROP, ST_AVAILABLE} state_t;

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    state_t              state_reg, state_next;
    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0] word_count_reg, word_count_next;
    logic [7:0]          last_mask_reg, last_mask_next;
    logic                busy_reg, busy_next;
    logic                resync_reg, resync_next;
    logic                available_reg, available_next;
    logic                empty_reg, empty_next;
    logic [7:0]          data_valid_reg, data_valid_next;
    logic [63:0]         rd_data_reg;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic                  mem_re;
    logic                  count_packet;
    logic                  count_drop;
    logic                  frame_open;

    logic [63:0] mem [0:(1 << ADDR_WIDTH) - 1];

    wire rx_word = |i_rx_data_valid;
    wire rx_end  = i_rx_good_frame | i_rx_bad_frame;

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        word_count_next = word_count_reg;
        last_mask_next  = last_mask_reg;
        busy_next       = busy_reg;
        resync_next     = resync_reg;
        available_next  = available_reg;
        empty_next      = empty_reg;
        data_valid_next = data_valid_reg;
        mem_we          = 1'b0;
        mem_waddr       = wr_ptr_reg[ADDR_WIDTH-1:0];
        mem_re          = 1'b0;
        count_packet    = 1'b0;
        count_drop      = 1'b0;
        frame_open      = busy_reg ? !rx_end : rx_word;

        case (state_reg)
            ST_IDLE: begin
                // After reset the MAC may be mid-frame: skip words until an idle cycle or end pulse.
                if (resync_reg) begin
                    if (rx_end || !rx_word)
                        resync_next = 1'b0;
                end else if (rx_word) begin
                    mem_we         = 1'b1;
                    mem_waddr      = '0;
                    wr_ptr_next    = PTR_ONE;
                    last_mask_next = i_rx_data_valid;
                    state_next     = ST_RECEIVE;
                end
            end

            ST_RECEIVE: begin
                if (i_rx_good_frame) begin
                    word_count_next = wr_ptr_reg;
                    rd_ptr_next     = '0;
                    available_next  = 1'b1;
                    empty_next      = 1'b0;
                    data_valid_next = last_mask_reg;
                    busy_next       = 1'b0;
                    state_next      = ST_AVAILABLE;
                end else if (i_rx_bad_frame) begin
                    count_drop  = 1'b1;
                    wr_ptr_next = '0;
                    state_next  = ST_IDLE;
                end else if (rx_word) begin
                    // Top pointer bit set means every RAM word is already used.
                    if (wr_ptr_reg[ADDR_WIDTH]) begin
                        state_next = ST_DROP;
                    end else begin
                        mem_we         = 1'b1;
                        wr_ptr_next    = wr_ptr_reg + PTR_ONE;
                        last_mask_next = i_rx_data_valid;
                    end
                end
            end

            ST_DROP: begin
                if (rx_end) begin
                    count_drop  = 1'b1;
                    wr_ptr_next = '0;
                    state_next  = ST_IDLE;
                end
            end

            ST_AVAILABLE: begin
                if (busy_reg && rx_end) begin
                    count_drop = 1'b1;
                    busy_next  = 1'b0;
                end else if (!busy_reg && rx_word) begin
                    busy_next = 1'b1;
                end

                if (i_dispatch_packet_read_discard) begin
                    count_packet    = 1'b1;
                    available_next  = 1'b0;
                    empty_next      = 1'b1;
                    data_valid_next = 8'h00;
                    wr_ptr_next     = '0;
                    rd_ptr_next     = '0;
                    word_count_next = '0;
                    busy_next       = 1'b0;
                    // A frame still streaming in must not be mistaken for a fresh one; finish it as a drop.
                    state_next      = frame_open ? ST_DROP : ST_IDLE;
                end else if (i_dispatch_fifo_rd_en && !empty_reg) begin
                    mem_re      = 1'b1;
                    rd_ptr_next = rd_ptr_reg + PTR_ONE;
                    empty_next  = ((rd_ptr_reg + PTR_ONE) == word_count_reg);
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            word_count_reg <= '0;
            last_mask_reg  <= 8'h00;
            busy_reg       <= 1'b0;
            resync_reg     <= 1'b1;
            available_reg  <= 1'b0;
            empty_reg      <= 1'b1;
            data_valid_reg <= 8'h00;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            word_count_reg <= word_count_next;
            last_mask_reg  <= last_mask_next;
            busy_reg       <= busy_next;
            resync_reg     <= resync_next;
            available_reg  <= available_next;
            empty_reg      <= empty_next;
            data_valid_reg <= data_valid_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_waddr] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_areset)
            rd_data_reg <= 64'h0;
        else if (mem_re)
            rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
    end

    assign o_dispatch_packet_available = available_reg;
    assign o_dispatch_fifo_empty       = empty_reg;
    assign o_dispatch_data_valid       = data_valid_reg;
    assign o_dispatch_fifo_rd_data     = rd_data_reg;

`ifdef NTS_DISPATCHER_COUNTERS_EN
    logic [31:0] packets_reg;
    logic [31:0] drops_reg;

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            packets_reg <= 32'h0;
            drops_reg   <= 32'h0;
        end else begin
            if (count_packet && (packets_reg != 32'hFFFF_FFFF))
                packets_reg <= packets_reg + 32'd1;
            if (count_drop && (drops_reg != 32'hFFFF_FFFF))
                drops_reg <= drops_reg + 32'd1;
        end
    end

    assign o_counter_packets = packets_reg;
    assign o_counter_drops   = drops_reg;
`else
    logic unused_count_events;
    assign unused_count_events = count_packet ^ count_drop;
    assign o_counter_packets   = 32'h0;
    assign o_counter_drops     = 32'h0;
`endif

endmodule

// File: tb/tb_nts_dispatcher_port.sv
// Scoreboard bench for nts_dispatcher_port: delivered frame words are queued as they are sent and popped on each read.
module tb_nts_dispatcher_port;

    localparam int AW = 2;
`ifdef NTS_DISPATCHER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  rx_valid;
    logic [63:0] rx_data;
    logic        rx_good;
    logic        rx_bad;
    logic        avail;
    logic        discard;
    logic [7:0]  dv;
    logic        empty;
    logic        rd_en;
    logic [63:0] rd_data;
    logic [31:0] cnt_packets;
    logic [31:0] cnt_drops;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_rd = 64'h0;
    int exp_packets = 0;
    int exp_drops   = 0;

    nts_dispatcher_port #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (clk),
        .i_areset                       (srst),
        .i_rx_data_valid                (rx_valid),
        .i_rx_data                      (rx_data),
        .i_rx_good_frame                (rx_good),
        .i_rx_bad_frame                 (rx_bad),
        .o_dispatch_packet_available    (avail),
        .i_dispatch_packet_read_discard (discard),
        .o_dispatch_data_valid          (dv),
        .o_dispatch_fifo_empty          (empty),
        .i_dispatch_fifo_rd_en          (rd_en),
        .o_dispatch_fifo_rd_data        (rd_data),
        .o_counter_packets              (cnt_packets),
        .o_counter_drops                (cnt_drops)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".packets"}, 64'(cnt_packets), CNT_EN ? 64'(exp_packets) : 64'h0);
        check({tag, ".drops"},   64'(cnt_drops),   CNT_EN ? 64'(exp_drops)   : 64'h0);
    endtask

    task automatic check_state(input string tag, input logic e_avail, input logic e_empty, input logic [7:0] e_dv);
        check({tag, ".avail"}, 64'(avail), 64'(e_avail));
        check({tag, ".empty"}, 64'(empty), 64'(e_empty));
        check({tag, ".dv"},    64'(dv),    64'(e_dv));
    endtask

    // kind: 0 = good end pulse, 1 = bad end pulse. pat = 0 gives random words.
    task automatic send_frame(input int n, input logic [7:0] last_mask, input bit kind,
                              input bit deliver, input logic [63:0] pat, input bit disc_on_end);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = (pat != 64'h0) ? pat * 64'(i + 1) : {$urandom, $urandom};
            if (deliver)
                exp_q.push_back(w);
            rx_valid = (i == n - 1) ? last_mask : 8'hFF;
            rx_data  = w;
            tick();
        end
        rx_valid = 8'h00;
        rx_data  = 64'h0;
        rx_good  = !kind;
        rx_bad   = kind;
        discard  = disc_on_end;
        tick();
        rx_good  = 1'b0;
        rx_bad   = 1'b0;
        discard  = 1'b0;
    endtask

    task automatic read_word(input string tag);
        logic [63:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (exp_q.size() != 0) begin
            exp     = exp_q.pop_front();
            last_rd = exp;
        end else begin
            exp = last_rd;
        end
        check(tag, rd_data, exp);
    endtask

    task automatic do_discard(input string tag);
        discard = 1'b1;
        tick();
        discard = 1'b0;
        exp_packets++;
        exp_q.delete();
        check_state(tag, 1'b0, 1'b1, 8'h00);
        check_counters(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1; rx_valid = 8'h00; rx_data = 64'h0; rx_good = 1'b0; rx_bad = 1'b0;
        discard = 1'b0; rd_en = 1'b0;
        tick(); tick();
        check_state("reset", 1'b0, 1'b1, 8'h00);
        check("reset.rd_data", rd_data, 64'h0);
        check_counters("reset");
        srst = 1'b0;
        tick();

        // Three-word good frame with a partial last word.
        send_frame(3, 8'hF0, 1'b0, 1'b1, 64'h1111_1111_1111_1111, 1'b0);
        check_state("good3", 1'b1, 1'b0, 8'hF0);
        read_word("good3.rd0");
        check("good3.empty0", 64'(empty), 64'h0);
        read_word("good3.rd1");
        read_word("good3.rd2");
        check("good3.empty2", 64'(empty), 64'h1);
        read_word("good3.rd_when_empty");
        do_discard("good3.discard");

        // Bad frames: one that overflows the 4-word buffer, one short.
        send_frame(5, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        exp_drops++;
        check("bad5.avail", 64'(avail), 64'h0);
        check_counters("bad5");
        send_frame(2, 8'hFF, 1'b1, 1'b0, 64'h0, 1'b0);
        exp_drops++;
        check("bad2.avail", 64'(avail), 64'h0);
        check_counters("bad2");
        send_frame(2, 8'hC0, 1'b0, 1'b1, 64'h0, 1'b0);
        check_state("good2", 1'b1, 1'b0, 8'hC0);
        read_word("good2.rd0");
        read_word("good2.rd1");
        check("good2.empty", 64'(empty), 64'h1);
        do_discard("good2.discard");

        // Overflow on a good frame, then exactly-full and single-word frames.
        send_frame(6, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b0);
        exp_drops++;
        check("ovf.avail", 64'(avail), 64'h0);
        check_counters("ovf");
        send_frame(4, 8'hFE, 1'b0, 1'b1, 64'h0, 1'b0);
        check_state("full4", 1'b1, 1'b0, 8'hFE);
        for (int i = 0; i < 4; i++) read_word("full4.rd");
        check("full4.empty", 64'(empty), 64'h1);
        do_discard("full4.discard");
        send_frame(1, 8'h80, 1'b0, 1'b1, 64'h0, 1'b0);
        check_state("one", 1'b1, 1'b0, 8'h80);
        read_word("one.rd0");
        do_discard("one.discard");

        // Second frame arriving while the first is held is dropped.
        send_frame(2, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0);
        send_frame(4, 8'h0F, 1'b0, 1'b0, 64'h0, 1'b0);
        exp_drops++;
        check_state("busy", 1'b1, 1'b0, 8'hFF);
        check_counters("busy");
        read_word("busy.rd0");
        read_word("busy.rd1");
        check("busy.empty", 64'(empty), 64'h1);
        do_discard("busy.discard");

        // Discard coinciding with a read after one of three words.
        send_frame(3, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0);
        read_word("coin.rd0");
        rd_en = 1'b1;
        discard = 1'b1;
        tick();
        rd_en = 1'b0;
        discard = 1'b0;
        exp_packets++;
        exp_q.delete();
        check_state("coin", 1'b0, 1'b1, 8'h00);
        check("coin.rd_hold", rd_data, last_rd);
        check_counters("coin");
        send_frame(1, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0);
        read_word("coin.next_rd0");
        do_discard("coin.next_discard");

        // Busy-frame end pulse coinciding with discard.
        send_frame(1, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0);
        send_frame(2, 8'hFF, 1'b0, 1'b0, 64'h0, 1'b1);
        exp_drops++;
        exp_packets++;
        exp_q.delete();
        check_state("busyend_disc", 1'b0, 1'b1, 8'h00);
        check_counters("busyend_disc");
        send_frame(2, 8'h3F, 1'b0, 1'b1, 64'h0, 1'b0);
        check_state("after_bd", 1'b1, 1'b0, 8'h3F);
        read_word("after_bd.rd0");
        read_word("after_bd.rd1");
        do_discard("after_bd.discard");

        // Reset in the middle of a 4-word frame.
        rx_valid = 8'hFF; rx_data = {$urandom, $urandom};
        tick();
        rx_data = {$urandom, $urandom};
        srst = 1'b1;
        tick();
        srst = 1'b0;
        exp_packets = 0;
        exp_drops = 0;
        check_state("midrst", 1'b0, 1'b1, 8'h00);
        check("midrst.rd_data", rd_data, 64'h0);
        check_counters("midrst");
        rx_data = {$urandom, $urandom};
        tick();
        rx_data = {$urandom, $urandom};
        tick();
        rx_valid = 8'h00; rx_data = 64'h0; rx_good = 1'b1;
        tick();
        rx_good = 1'b0;
        tick();
        check_state("midrst.tail", 1'b0, 1'b1, 8'h00);
        check_counters("midrst.tail");
        send_frame(2, 8'hFF, 1'b0, 1'b1, 64'h0, 1'b0);
        check_state("fresh", 1'b1, 1'b0, 8'hFF);
        read_word("fresh.rd0");
        read_word("fresh.rd1");
        do_discard("fresh.discard");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
